wb_accel_sequencer: RTL and testbench
=====================================

Name: wb_accel_sequencer

Overview:
Wishbone-slave controller that sequences the four arithmetic engines (FP MAC, 16-bit CLA, 2D systolic array, radix-8 multiplier) from firmware. It replaces direct logic-analyzer driving with operand registers, a start command, engine-specific latency timing and result capture. Only one engine runs at a time. It raises a maskable interrupt on completion.

Parameters:
BASE_ADDR, 32'h3000_0000, Wishbone base; bits [31:8] are decoded.
LAT0, 4, FP MAC result latency in cycles (1..255).
LAT1, 1, CLA result latency.
LAT2, 8, systolic array result latency.
LAT3, 3, radix-8 multiplier result latency.

Ports:
wb_clk_i  in  1  single clock.
wb_rst_i  in  1  synchronous, active-high reset.
wbs_stb_i, wbs_cyc_i, wbs_we_i  in  1 each  Wishbone strobe, cycle and write enable.
wbs_sel_i  in  4  byte selects.
wbs_adr_i, wbs_dat_i  in  32 each  address and write data.
wbs_ack_o  out  1  acknowledge.
wbs_dat_o  out  32  read data.
eng_a, eng_b  out  32 each  operands, held stable for the whole operation.
eng_rnd  out  2  FP rounding mode.
eng_sel  out  2  active engine: 0 FMAC, 1 CLA, 2 SA, 3 MB8.
eng_clr  out  1  one-cycle engine clear pulse.
res_fmac  in  32  FP MAC result.
res_cla  in  17  CLA result {cout, sum}.
res_sa  in  32  systolic array result.
res_mb  in  26  radix-8 multiplier result.
user_irq  out  1  completion interrupt.

Behaviour:
- Reset: all registers 0, FSM in IDLE, all outputs 0.
- Wishbone access:
  - Decoded when stb&cyc and adr[31:8]==BASE_ADDR[31:8].
  - ack is registered: one cycle after the request, high for exactly 1 cycle, then low for at least 1 cycle. No wait states.
  - Undecoded addresses: never acked.
  - Reads of unmapped offsets return 0. wbs_dat_o is valid with ack, otherwise 0.
- Registers (offset = adr[7:0]):
  - 0x00 CTRL RW:
    - [0] START: write-1 triggers; reads 0.
    - [2:1] ENG, [4:3] RND, [5] IRQ_EN.
    - Written only when sel[0]=1.
  - 0x04 STATUS:
    - [0] BUSY, RO.
    - [1] DONE, sticky, write-1-to-clear.
    - [2] ERR, sticky, write-1-to-clear.
  - 0x08 OPA, 0x0C OPB: RW shadow registers with per-byte sel writes.
  - 0x10 RESULT: RO, zero-extended result of the last operation.
  - 0x14 CYCLES: RO, cycles from START ack to DONE for the last operation.
- FSM: IDLE -> CLEAR -> RUN -> CAPTURE -> IDLE.
  - IDLE: START write in cycle T moves to CLEAR at T+1. In the same edge, latch OPA/OPB/ENG/RND into eng_a/eng_b/eng_sel/eng_rnd, set BUSY, clear DONE.
  - CLEAR: eng_clr=1 for exactly this one cycle.
  - RUN: counter loaded with LAT[ENG]-1 on entry, decrements each cycle; at 0 go to CAPTURE.
  - CAPTURE: sample the selected res_* into RESULT and zero-extend. Set DONE, clear BUSY, write CYCLES=LAT+2, return to IDLE.
  - Total from START ack edge to DONE visible: LAT+2 cycles.
- Operand handling:
  - OPA/OPB/CTRL writes during BUSY update the shadow registers only.
  - eng_* outputs stay frozen until the next START.
  - eng_* outputs keep their last values in IDLE.
- START while BUSY: ignored, ERR set, current operation unaffected.
- Simultaneous events:
  - If DONE is set in CAPTURE in the same cycle as a W1C write to DONE, set wins.
  - W1C of a bit that is 0: no effect.
- user_irq = DONE & IRQ_EN, as a level. Clearing DONE or IRQ_EN drops it next cycle.
- Reset mid-operation: FSM returns to IDLE and all state goes to 0. No partial result or DONE is produced.

Test Plan:
- Reset, then read STATUS/RESULT/CYCLES -> all 0; eng_* = 0, user_irq = 0.
- OPA=0x0000_1234, OPB=0x0000_1111, CTRL=ENG1|START, res_cla driven to 0x02345 -> eng_clr pulses 1 cycle; DONE after 3 cycles; RESULT=0x0000_2345; CYCLES=3.
- ENG2 start with LAT2=8, IRQ_EN=1 -> BUSY for 10 cycles; user_irq rises with DONE; W1C DONE -> irq low the next cycle.
- START issued while an ENG0 operation is BUSY -> ERR=1; original op completes with CYCLES=6; eng_sel stays 0 throughout.
- Write OPA=0xDEAD_BEEF during BUSY -> eng_a unchanged during the op; next START presents 0xDEADBEEF. sel=4'b0011 write of 0xFFFF_FFFF to OPA=0 -> OPA=0x0000_FFFF.
- Assert wb_rst_i mid-RUN -> next cycle BUSY=0, DONE=0, eng_* = 0; access to address BASE+0x100 -> no ack.

Source files
------------

// File: rtl/wb_accel_sequencer.sv
// Wishbone-slave sequencer for the four arithmetic engines: operand shadows,
// a START command, per-engine latency timing, result capture and a completion IRQ.
module wb_accel_sequencer #(
  parameter logic [31:0] BASE_ADDR = 32'h3000_0000,
  parameter int          LAT0      = 4,
  parameter int          LAT1      = 1,
  parameter int          LAT2      = 8,
  parameter int          LAT3      = 3
) (
  input  logic        wb_clk_i,
  input  logic        wb_rst_i,
  input  logic        wbs_stb_i,
  input  logic        wbs_cyc_i,
  input  logic        wbs_we_i,
  input  logic [3:0]  wbs_sel_i,
  input  logic [31:0] wbs_adr_i,
  input  logic [31:0] wbs_dat_i,
  output logic        wbs_ack_o,
  output logic [31:0] wbs_dat_o,
  output logic [31:0] eng_a,
  output logic [31:0] eng_b,
  output logic [1:0]  eng_rnd,
  output logic [1:0]  eng_sel,
  output logic        eng_clr,
  input  logic [31:0] res_fmac,
  input  logic [16:0] res_cla,
  input  logic [31:0] res_sa,
  input  logic [25:0] res_mb,
  output logic        user_irq
);

  typedef enum logic [1:0] {IDLE, CLEAR, RUN, CAPTURE} state_t;

  state_t      state_q, state_d;
  logic [7:0]  cnt_q, cnt_d;
  logic        ack_q, ack_d;
  logic [31:0] dat_q, dat_d;
  logic [1:0]  eng_sh_q, eng_sh_d, rnd_sh_q, rnd_sh_d;
  logic        irq_en_q, irq_en_d, done_q, done_d, err_q, err_d;
  logic [31:0] opa_q, opa_d, opb_q, opb_d;
  logic [31:0] result_q, result_d, cycles_q, cycles_d;
  logic [31:0] eng_a_q, eng_a_d, eng_b_q, eng_b_d;
  logic [1:0]  eng_sel_q, eng_sel_d, eng_rnd_q, eng_rnd_d;

  logic        access, wr, start_wr, busy;
  logic [7:0]  off;
  logic [31:0] rdata;

  function automatic logic [7:0] lat_of(input logic [1:0] e);
    case (e)
      2'd0:    lat_of = 8'(LAT0);
      2'd1:    lat_of = 8'(LAT1);
      2'd2:    lat_of = 8'(LAT2);
      default: lat_of = 8'(LAT3);
    endcase
  endfunction

  // A request is served once; the cycle after ack is forced idle by ~ack_q.
  assign access   = wbs_stb_i & wbs_cyc_i & (wbs_adr_i[31:8] == BASE_ADDR[31:8]) & ~ack_q;
  assign wr       = access & wbs_we_i;
  assign off      = wbs_adr_i[7:0];
  assign start_wr = wr & (off == 8'h00) & wbs_sel_i[0] & wbs_dat_i[0];
  assign busy     = (state_q != IDLE);

  always_comb begin
    rdata = '0;
    case (off)
      8'h00:   rdata = {26'b0, irq_en_q, rnd_sh_q, eng_sh_q, 1'b0};
      8'h04:   rdata = {29'b0, err_q, done_q, busy};
      8'h08:   rdata = opa_q;
      8'h0C:   rdata = opb_q;
      8'h10:   rdata = result_q;
      8'h14:   rdata = cycles_q;
      default: rdata = '0;
    endcase
  end

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    ack_d     = access;
    dat_d     = (access && !wbs_we_i) ? rdata : 32'b0;
    eng_sh_d  = eng_sh_q;
    rnd_sh_d  = rnd_sh_q;
    irq_en_d  = irq_en_q;
    done_d    = done_q;
    err_d     = err_q;
    opa_d     = opa_q;
    opb_d     = opb_q;
    result_d  = result_q;
    cycles_d  = cycles_q;
    eng_a_d   = eng_a_q;
    eng_b_d   = eng_b_q;
    eng_sel_d = eng_sel_q;
    eng_rnd_d = eng_rnd_q;

    if (wr) begin
      case (off)
        8'h00: if (wbs_sel_i[0]) begin
          eng_sh_d = wbs_dat_i[2:1];
          rnd_sh_d = wbs_dat_i[4:3];
          irq_en_d = wbs_dat_i[5];
        end
        8'h04: if (wbs_sel_i[0]) begin
          if (wbs_dat_i[1]) done_d = 1'b0;
          if (wbs_dat_i[2]) err_d  = 1'b0;
        end
        8'h08: for (int i = 0; i < 4; i++)
          if (wbs_sel_i[i]) opa_d[8*i +: 8] = wbs_dat_i[8*i +: 8];
        8'h0C: for (int i = 0; i < 4; i++)
          if (wbs_sel_i[i]) opb_d[8*i +: 8] = wbs_dat_i[8*i +: 8];
        default: ;
      endcase
    end

    // The FSM follows the register writes so a capture-time DONE beats a W1C.
    case (state_q)
      IDLE: if (start_wr) begin
        state_d   = CLEAR;
        eng_a_d   = opa_q;
        eng_b_d   = opb_q;
        eng_sel_d = wbs_dat_i[2:1];
        eng_rnd_d = wbs_dat_i[4:3];
        done_d    = 1'b0;
      end
      CLEAR: begin
        state_d = RUN;
        cnt_d   = lat_of(eng_sel_q) - 8'd1;
      end
      RUN: begin
        if (cnt_q == 8'd0) state_d = CAPTURE;
        else               cnt_d   = cnt_q - 8'd1;
      end
      CAPTURE: begin
        case (eng_sel_q)
          2'd0:    result_d = res_fmac;
          2'd1:    result_d = {15'b0, res_cla};
          2'd2:    result_d = res_sa;
          default: result_d = {6'b0, res_mb};
        endcase
        cycles_d = 32'(lat_of(eng_sel_q)) + 32'd2;
        done_d   = 1'b1;
        state_d  = IDLE;
      end
      default: state_d = IDLE;
    endcase

    if (start_wr && busy) err_d = 1'b1;
  end

  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      ack_q     <= 1'b0;
      dat_q     <= '0;
      eng_sh_q  <= '0;
      rnd_sh_q  <= '0;
      irq_en_q  <= 1'b0;
      done_q    <= 1'b0;
      err_q     <= 1'b0;
      opa_q     <= '0;
      opb_q     <= '0;
      result_q  <= '0;
      cycles_q  <= '0;
      eng_a_q   <= '0;
      eng_b_q   <= '0;
      eng_sel_q <= '0;
      eng_rnd_q <= '0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      ack_q     <= ack_d;
      dat_q     <= dat_d;
      eng_sh_q  <= eng_sh_d;
      rnd_sh_q  <= rnd_sh_d;
      irq_en_q  <= irq_en_d;
      done_q    <= done_d;
      err_q     <= err_d;
      opa_q     <= opa_d;
      opb_q     <= opb_d;
      result_q  <= result_d;
      cycles_q  <= cycles_d;
      eng_a_q   <= eng_a_d;
      eng_b_q   <= eng_b_d;
      eng_sel_q <= eng_sel_d;
      eng_rnd_q <= eng_rnd_d;
    end
  end

  assign wbs_ack_o = ack_q;
  assign wbs_dat_o = dat_q;
  assign eng_a     = eng_a_q;
  assign eng_b     = eng_b_q;
  assign eng_sel   = eng_sel_q;
  assign eng_rnd   = eng_rnd_q;
  assign eng_clr   = (state_q == CLEAR);
  assign user_irq  = done_q & irq_en_q;

endmodule

// File: tb/tb_wb_accel_sequencer.sv
// Self-checking bench for wb_accel_sequencer: directed scenarios plus randomized
// operations checked against a register-level reference model.
module tb_wb_accel_sequencer;

  localparam logic [31:0] BASE = 32'h3000_0000;
  localparam logic [7:0] A_CTRL = 8'h00, A_STAT = 8'h04, A_OPA = 8'h08,
                         A_OPB = 8'h0C, A_RES = 8'h10, A_CYC = 8'h14;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        stb = 1'b0, cyc = 1'b0, we = 1'b0;
  logic [3:0]  sel = 4'h0;
  logic [31:0] adr = '0, wdat = '0;
  logic        ack;
  logic [31:0] rdat;
  logic [31:0] eng_a, eng_b;
  logic [1:0]  eng_rnd, eng_sel;
  logic        eng_clr, user_irq;
  logic [31:0] r_val [4];

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model: latency and result width per engine, plus shadow state.
  int          lat_tab [4] = '{4, 1, 8, 3};
  int          wid_tab [4] = '{32, 17, 32, 26};
  logic [31:0] m_opa = '0, m_opb = '0;
  logic        m_err = 1'b0;

  wb_accel_sequencer dut (
    .wb_clk_i (clk),       .wb_rst_i (rst),
    .wbs_stb_i(stb),       .wbs_cyc_i(cyc),       .wbs_we_i (we),
    .wbs_sel_i(sel),       .wbs_adr_i(adr),       .wbs_dat_i(wdat),
    .wbs_ack_o(ack),       .wbs_dat_o(rdat),
    .eng_a    (eng_a),     .eng_b    (eng_b),     .eng_rnd  (eng_rnd),
    .eng_sel  (eng_sel),   .eng_clr  (eng_clr),
    .res_fmac (r_val[0]),  .res_cla  (r_val[1][16:0]),
    .res_sa   (r_val[2]),  .res_mb   (r_val[3][25:0]),
    .user_irq (user_irq)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("[TB] FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  // Single Wishbone write; also keeps the model's operand shadows up to date.
  task automatic applyStimulus(input logic [7:0] off, input logic [31:0] d, input logic [3:0] s);
    bit got = 0;
    @(posedge clk); #1;
    stb = 1; cyc = 1; we = 1; sel = s; adr = BASE | 32'(off); wdat = d;
    for (int k = 0; k < 4 && !got; k++) begin
      @(posedge clk); #1;
      got = ack;
    end
    stb = 0; cyc = 0; we = 0;
    checkOutput("write_ack", {31'b0, got}, 32'd1);
    for (int i = 0; i < 4; i++) begin
      if (s[i] && off == A_OPA) m_opa[8*i +: 8] = d[8*i +: 8];
      if (s[i] && off == A_OPB) m_opb[8*i +: 8] = d[8*i +: 8];
    end
  endtask

  task automatic readReg(input logic [7:0] off, output logic [31:0] d);
    bit got = 0;
    d = 'x;
    @(posedge clk); #1;
    stb = 1; cyc = 1; we = 0; sel = 4'hF; adr = BASE | 32'(off);
    for (int k = 0; k < 4 && !got; k++) begin
      @(posedge clk); #1;
      got = ack;
      if (got) d = rdat;
    end
    stb = 0; cyc = 0;
    checkOutput("read_ack", {31'b0, got}, 32'd1);
  endtask

  task automatic checkReg(input string tag, input logic [7:0] off, input logic [31:0] exp);
    logic [31:0] v;
    readReg(off, v);
    checkOutput(tag, v, exp);
  endtask

  // Start an operation with IRQ enabled, time it via user_irq, then verify results.
  task automatic startAndCheck(input logic [1:0] eng, input logic [1:0] rnd);
    logic [31:0] ctrl = {26'b0, 1'b1, rnd, eng, 1'b1};
    logic [31:0] exp_res;
    int n = 0, clr = 0;
    exp_res = 32'(64'(r_val[eng]) & ((64'd1 << wid_tab[eng]) - 64'd1));
    applyStimulus(A_CTRL, ctrl, 4'h1);
    checkOutput("eng_sel", {30'b0, eng_sel}, {30'b0, eng});
    checkOutput("eng_rnd", {30'b0, eng_rnd}, {30'b0, rnd});
    checkOutput("eng_a", eng_a, m_opa);
    checkOutput("eng_b", eng_b, m_opb);
    while (!user_irq && n < 400) begin
      if (eng_clr) clr++;
      @(posedge clk); #1;
      n++;
    end
    checkOutput("done_latency", 32'(n), 32'(lat_tab[eng] + 2));
    checkOutput("clr_pulses", 32'(clr), 32'd1);
    checkReg("result", A_RES, exp_res);
    checkReg("cycles", A_CYC, 32'(lat_tab[eng] + 2));
    checkReg("status_done", A_STAT, {29'b0, m_err, 2'b10});
    checkReg("ctrl_rb", A_CTRL, ctrl & 32'h3E);
    applyStimulus(A_STAT, 32'h2, 4'h1);
    checkOutput("irq_after_w1c", {31'b0, user_irq}, 32'd0);
  endtask

  initial begin
    logic [31:0] v, held_a;
    int acks, n;
    for (int i = 0; i < 4; i++) r_val[i] = $urandom;

    // Reset state
    repeat (3) @(posedge clk);
    #1 rst = 0;
    checkOutput("rst_eng_a", eng_a, 0);
    checkOutput("rst_eng_b", eng_b, 0);
    checkOutput("rst_eng_sel", {30'b0, eng_sel}, 0);
    checkOutput("rst_eng_rnd", {30'b0, eng_rnd}, 0);
    checkOutput("rst_eng_clr", {31'b0, eng_clr}, 0);
    checkOutput("rst_irq", {31'b0, user_irq}, 0);
    checkOutput("rst_dat_o", rdat, 0);
    checkReg("rst_status", A_STAT, 0);
    checkReg("rst_result", A_RES, 0);
    checkReg("rst_cycles", A_CYC, 0);

    // CLA: 1-cycle latency, 17-bit result zero-extended
    applyStimulus(A_OPA, 32'h0000_1234, 4'hF);
    applyStimulus(A_OPB, 32'h0000_1111, 4'hF);
    r_val[1] = 32'hFFFE_2345;
    startAndCheck(2'd1, 2'd0);
    checkReg("cla_result", A_RES, 32'h0000_2345);

    // Systolic array: 10 busy cycles, IRQ follows DONE
    startAndCheck(2'd2, 2'd1);

    // START while busy sets ERR; the running FMAC op is unaffected
    held_a = m_opa;
    applyStimulus(A_CTRL, 32'h21, 4'h1);
    applyStimulus(A_CTRL, 32'h25, 4'h1);
    applyStimulus(A_OPA, 32'hDEAD_BEEF, 4'hF);
    checkOutput("busy_eng_sel", {30'b0, eng_sel}, 0);
    checkOutput("busy_eng_a", eng_a, held_a);
    n = 0;
    while (!user_irq && n < 400) begin
      @(posedge clk); #1;
      n++;
    end
    checkOutput("err_op_done", {31'b0, user_irq}, 32'd1);
    checkOutput("err_eng_sel", {30'b0, eng_sel}, 0);
    checkReg("err_cycles", A_CYC, 32'd6);
    checkReg("err_result", A_RES, r_val[0]);
    checkReg("err_status", A_STAT, 32'h6);
    applyStimulus(A_STAT, 32'h6, 4'h1);
    checkReg("w1c_status", A_STAT, 0);
    m_err = 0;
    startAndCheck(2'd3, 2'd2);
    checkOutput("new_eng_a", eng_a, 32'hDEAD_BEEF);

    // Partial byte-select write
    applyStimulus(A_OPA, 32'h0, 4'hF);
    applyStimulus(A_OPA, 32'hFFFF_FFFF, 4'b0011);
    checkReg("opa_bytesel", A_OPA, 32'h0000_FFFF);

    // DONE without IRQ_EN; enabling later raises the level
    applyStimulus(A_CTRL, 32'h07, 4'h1);
    repeat (8) @(posedge clk);
    #1 checkOutput("noirq_level", {31'b0, user_irq}, 0);
    checkReg("noirq_status", A_STAT, 32'h2);
    applyStimulus(A_CTRL, 32'h26, 4'h1);
    checkOutput("irq_en_late", {31'b0, user_irq}, 32'd1);
    applyStimulus(A_STAT, 32'h2, 4'h1);

    // Randomized operations
    for (int i = 0; i < 8; i++) begin
      for (int j = 0; j < 4; j++) r_val[j] = $urandom;
      applyStimulus(A_OPA, $urandom, 4'($urandom_range(0, 15)));
      applyStimulus(A_OPB, $urandom, 4'hF);
      startAndCheck(2'($urandom_range(0, 3)), 2'($urandom_range(0, 3)));
    end

    // Unmapped offset reads 0; undecoded address never acks
    checkReg("unmapped_rd", 8'h18, 0);
    @(posedge clk); #1;
    stb = 1; cyc = 1; we = 0; adr = BASE + 32'h100;
    acks = 0;
    repeat (5) begin
      @(posedge clk); #1;
      if (ack) acks++;
    end
    stb = 0; cyc = 0;
    checkOutput("undecoded_ack", 32'(acks), 0);

    // Reset in the middle of RUN
    applyStimulus(A_CTRL, 32'h25, 4'h1);
    repeat (3) @(posedge clk);
    #1 rst = 1;
    @(posedge clk);
    #1 rst = 0;
    checkOutput("mid_rst_eng_a", eng_a, 0);
    checkOutput("mid_rst_eng_sel", {30'b0, eng_sel}, 0);
    checkOutput("mid_rst_irq", {31'b0, user_irq}, 0);
    repeat (12) @(posedge clk);
    checkReg("mid_rst_status", A_STAT, 0);
    checkReg("mid_rst_result", A_RES, 0);
    checkReg("mid_rst_opa", A_OPA, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
